// File: rtl/tdm_demux4_rx_pkg.sv
// Shared definitions for the 4-slot TDM link receiver: slot geometry, miss counter width, FSM states.
package tdm_demux4_rx_pkg;

  localparam int unsigned SLOTS  = 4;
  localparam int unsigned SLOT_W = 2;
  localparam int unsigned MISS_W = 3;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux4_rx_if.sv
// Link-side bundle of the TDM receiver: serial input beat plus re-expanded frame outputs.
interface tdm_demux4_rx_if
  import tdm_demux4_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0]  din;
  logic              din_valid;
  logic              frame_sync;
  logic [WIDTH-1:0]  out0;
  logic [WIDTH-1:0]  out1;
  logic [WIDTH-1:0]  out2;
  logic [WIDTH-1:0]  out3;
  logic [SLOT_W-1:0] sel;
  logic              frame_valid;
  logic              locked;
  logic              sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  out0, out1, out2, out3, sel, frame_valid, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output out0, out1, out2, out3, sel, frame_valid, locked, sync_err
  );

endinterface

// File: rtl/tdm_demux4_rx_slot_counter.sv
// Wrapping slot-position counter; clear to 0 beats load-to-1 beats increment.
module tdm_demux4_rx_slot_counter
  import tdm_demux4_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SLOT_W'(1);
    end else if (inc) begin
      cnt <= cnt + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4_rx.sv
// TDM 4-slot receiver: locks onto frame_sync, collects four beats, publishes them as one frame.
module tdm_demux4_rx
  import tdm_demux4_rx_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned MISS_LIMIT = 2
)
(
  input  logic           clk,
  input  logic           rst_n,
  tdm_demux4_rx_if.slave link
);

  state_t            state;
  logic [SLOT_W-1:0] sel;
  logic [MISS_W-1:0] miss;
  logic [MISS_W-1:0] miss_inc;
  logic              miss_hit;
  logic [WIDTH-1:0]  shadow0;
  logic [WIDTH-1:0]  shadow1;
  logic [WIDTH-1:0]  shadow2;
  logic [WIDTH-1:0]  out0;
  logic [WIDTH-1:0]  out1;
  logic [WIDTH-1:0]  out2;
  logic [WIDTH-1:0]  out3;
  logic              frame_valid;
  logic              sync_err;
  logic              cnt_inc;
  logic              cnt_load1;
  logic              cnt_clr;

  assign miss_inc = miss + MISS_W'(1);
  assign miss_hit = (miss_inc == MISS_W'(MISS_LIMIT));

  // Slot counter control; any accepted frame_sync re-anchors the frame at slot 0
  always_comb begin
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_clr   = 1'b0;
    if (link.din_valid) begin
      if (state == ST_HUNT) begin
        cnt_load1 = link.frame_sync;
      end else if (link.frame_sync) begin
        cnt_load1 = 1'b1;
      end else if ((sel == '0) && miss_hit) begin
        cnt_clr = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  tdm_demux4_rx_slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .cnt   (sel)
  );

  // Lock FSM, shadow capture and frame publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      miss        <= '0;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (link.din_valid) begin
        case (state)
          ST_HUNT: begin
            if (link.frame_sync) begin
              shadow0 <= link.din;
              miss    <= '0;
              state   <= ST_LOCK;
            end
          end
          ST_LOCK: begin
            if (link.frame_sync) begin
              // Resync mid-frame drops the partial frame; shadows are simply overwritten
              shadow0  <= link.din;
              miss     <= '0;
              sync_err <= (sel != '0);
            end else if (sel == '0) begin
              if (miss_hit) begin
                state <= ST_HUNT;
                miss  <= '0;
              end else begin
                shadow0 <= link.din;
                miss    <= miss_inc;
              end
            end else if (sel == SLOT_W'(1)) begin
              shadow1 <= link.din;
            end else if (sel == SLOT_W'(2)) begin
              shadow2 <= link.din;
            end else if (sel == SLOT_W'(SLOTS - 1)) begin
              out0        <= shadow0;
              out1        <= shadow1;
              out2        <= shadow2;
              out3        <= link.din;
              frame_valid <= 1'b1;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign link.out0        = out0;
  assign link.out1        = out1;
  assign link.out2        = out2;
  assign link.out3        = out3;
  assign link.sel         = sel;
  assign link.frame_valid = frame_valid;
  assign link.sync_err    = sync_err;
  assign link.locked      = (state == ST_LOCK);

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// Bench for tdm_demux4_rx: directed scenarios plus random beats against a frame-queue model.
module tb_tdm_demux4_rx;
  import tdm_demux4_rx_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned ML = 2;
  localparam int unsigned VW = 4*W + SLOT_W + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nvec  = 0;
  int   nerr  = 0;

  always #5 clk = ~clk;

  tdm_demux4_rx_if #(.WIDTH(W)) link();

  tdm_demux4_rx #(.WIDTH(W), .MISS_LIMIT(ML)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link.slave)
  );

  // Model: a queue holds the samples of the frame in progress; its length is the slot position
  bit           m_lock;
  int           m_miss;
  logic [W-1:0] q[$];
  logic [W-1:0] m_out[4];
  bit           m_fv;
  bit           m_err;

  function automatic void model_reset();
    m_lock = 0; m_miss = 0; q.delete(); m_fv = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_out[i] = '0;
  endfunction

  function automatic void model_beat(input logic [W-1:0] d, input bit v, input bit f);
    m_fv = 0; m_err = 0;
    if (!v) return;
    if (!m_lock) begin
      if (f) begin m_lock = 1; q = {d}; m_miss = 0; end
    end else if (f) begin
      if (q.size() != 0) m_err = 1;
      q = {d}; m_miss = 0;
    end else if (q.size() == 0) begin
      m_miss++;
      if (m_miss >= ML) begin m_lock = 0; m_miss = 0; end
      else q.push_back(d);
    end else begin
      q.push_back(d);
      if (q.size() == 4) begin
        for (int i = 0; i < 4; i++) m_out[i] = q[i];
        m_fv = 1;
        q.delete();
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [SLOT_W-1:0] s;
    s = m_lock ? SLOT_W'(q.size()) : '0;
    return {m_out[0], m_out[1], m_out[2], m_out[3], s, m_fv, m_lock, m_err};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {link.out0, link.out1, link.out2, link.out3, link.sel,
            link.frame_valid, link.locked, link.sync_err};
  endfunction

  // Drive one cycle at the falling edge, advance the model, land just after the rising edge
  task automatic step(input logic [W-1:0] d, input logic v, input logic f);
    @(negedge clk);
    link.din = d; link.din_valid = v; link.frame_sync = f;
    model_beat(d, v, f);
    @(posedge clk);
    #1;
    link.din_valid = 1'b0; link.frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    link.din = '0; link.din_valid = 1'b0; link.frame_sync = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (obs_vec() !== exp_vec()) begin
      nerr++; $display("FAIL reset: got %h expected %h", obs_vec(), exp_vec());
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [W-1:0] pat[4];
    pat[0] = W'(1); pat[1] = W'(0); pat[2] = W'(1); pat[3] = W'(1);
    for (int i = 0; i < 4; i++) begin
      step(pat[i], 1'b1, i == 0);
      nvec++;
      if (obs_vec() !== exp_vec()) begin
        nerr++; $display("FAIL basic beat%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    nvec++;
    if ({link.out0, link.out1, link.out2, link.out3, link.frame_valid} !== {W'(1), W'(0), W'(1), W'(1), 1'b1}) begin
      nerr++; $display("FAIL basic frame: got %h/%h/%h/%h fv=%b expected 1/0/1/1 fv=1",
                       link.out0, link.out1, link.out2, link.out3, link.frame_valid);
    end
  endtask

  task automatic test_gap();
    int fvc = 0;
    logic [W-1:0] pat[4];
    for (int i = 0; i < 4; i++) pat[i] = W'($urandom);
    for (int i = 0; i < 4; i++) begin
      step(pat[i], 1'b1, i == 0);
      if (link.frame_valid) fvc++;
      nvec++;
      if (obs_vec() !== exp_vec()) begin
        nerr++; $display("FAIL gap beat%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        for (int g = 0; g < 3; g++) begin
          step(W'($urandom), 1'b0, 1'b0);
          if (link.frame_valid) fvc++;
          nvec++;
          if (link.sel !== SLOT_W'(2) || obs_vec() !== exp_vec()) begin
            nerr++; $display("FAIL gap idle%0d: got %h expected %h", g, obs_vec(), exp_vec());
          end
        end
      end
    end
    nvec++;
    if (fvc != 1) begin
      nerr++; $display("FAIL gap pulses: got %0d expected 1", fvc);
    end
  endtask

  task automatic test_resync();
    step(W'(3), 1'b1, 1'b1);
    step(W'(4), 1'b1, 1'b0);
    step(W'(9), 1'b1, 1'b1);
    nvec++;
    if ({link.sync_err, link.frame_valid, link.sel} !== {1'b1, 1'b0, SLOT_W'(1)} || obs_vec() !== exp_vec()) begin
      nerr++; $display("FAIL resync err: got %h expected %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step(W'(10 + i), 1'b1, 1'b0);
      nvec++;
      if (obs_vec() !== exp_vec()) begin
        nerr++; $display("FAIL resync beat%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    nvec++;
    if ({link.out0, link.out1, link.out2, link.out3, link.frame_valid} !== {W'(9), W'(10), W'(11), W'(12), 1'b1}) begin
      nerr++; $display("FAIL resync frame: got %h/%h/%h/%h fv=%b expected 9/a/b/c fv=1",
                       link.out0, link.out1, link.out2, link.out3, link.frame_valid);
    end
  endtask

  task automatic test_loss_of_lock();
    for (int fr = 0; fr < 3; fr++) begin
      for (int i = 0; i < 4; i++) begin
        step(W'($urandom), 1'b1, (fr == 0) && (i == 0));
        nvec++;
        if (obs_vec() !== exp_vec()) begin
          nerr++; $display("FAIL loss f%0d b%0d: got %h expected %h", fr, i, obs_vec(), exp_vec());
        end
        if (fr == 2 && i == 0) begin
          nvec++;
          if ({link.locked, link.sel} !== {1'b0, SLOT_W'(0)}) begin
            nerr++; $display("FAIL loss drop: got locked=%b sel=%0d expected locked=0 sel=0", link.locked, link.sel);
          end
        end
      end
    end
  endtask

  task automatic test_hunt_discard();
    for (int i = 0; i < 6; i++) begin
      step(W'($urandom), 1'b1, 1'b0);
      nvec++;
      if (link.locked !== 1'b0 || obs_vec() !== exp_vec()) begin
        nerr++; $display("FAIL hunt beat%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    step(W'(5), 1'b1, 1'b1);
    step(W'(6), 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    nvec++;
    if (obs_vec() !== exp_vec()) begin
      nerr++; $display("FAIL async reset: got %h expected %h", obs_vec(), exp_vec());
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(W'(7 + i), 1'b1, 1'b0);
      nvec++;
      if (link.frame_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
        nerr++; $display("FAIL post-reset beat%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit v, f, slot0;
    for (int n = 0; n < 600; n++) begin
      slot0 = m_lock && (q.size() == 0);
      v = ($urandom_range(3) != 0);
      f = slot0 ? ($urandom_range(4) != 0) : ($urandom_range(15) == 0);
      step(W'($urandom), v, f);
      nvec++;
      if (obs_vec() !== exp_vec()) begin
        nerr++; $display("FAIL random #%0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gap();
    test_resync();
    test_loss_of_lock();
    test_hunt_discard();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
